// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, ALU operations, immediate formats, writeback select.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASSB
    } alu_op_e;

    typedef enum logic [2:0] { IMM_I, IMM_S, IMM_B, IMM_U, IMM_J } imm_e;

    typedef enum logic [1:0] { WB_ALU, WB_MEM, WB_PC4 } wb_sel_e;

    // funct3/funct7 to ALU operation; SUB exists only for register-register ops
    function automatic alu_op_e decode_alu(input logic [2:0] f3, input logic f7b5, input logic is_reg);
        case (f3)
            3'b000:  return (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Sign-extended immediate for each instruction format
    function automatic logic [31:0] gen_imm(input logic [31:0] ins, input imm_e t);
        case (t)
            IMM_I:   return {{20{ins[31]}}, ins[31:20]};
            IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   return {ins[31:12], 12'b0};
            IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/top_alu.sv
// 32-bit integer ALU with zero flag.
module alu
    import riscv_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [31:0] result,
    output logic        zero
);

    // Select the operation result; shifts use b[4:0]
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_SLL:   result = a << b[4:0];
            ALU_SRL:   result = a >> b[4:0];
            ALU_SRA:   result = $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:   result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:  result = {31'b0, a < b};
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/top.sv
// Single-cycle RV32I core: PC, ROM, register file, decoder, ALU, data RAM.
module rom #(
    parameter int unsigned WORDS = 1024
) (
    input  logic        CLK,
    input  logic [9:0]  addr,
    output logic [31:0] data,
    input  logic        prog_we,
    input  logic [9:0]  prog_addr,
    input  logic [31:0] prog_data
);
    localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    logic [31:0] MROM [0:WORDS-1];

    // Spare programming port, tied off in the core; images normally arrive by hierarchical load
    always_ff @(posedge CLK) begin
        if (prog_we) MROM[prog_addr[AW-1:0]] <= prog_data;
    end

    assign data = MROM[addr[AW-1:0]];
endmodule

module ram #(
    parameter int unsigned WORDS = 1024
) (
    input  logic        CLK,
    input  logic        we,
    input  logic [9:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    logic [31:0] MRAM [0:WORDS-1];

    // Word write at the end of the store cycle
    always_ff @(posedge CLK) begin
        if (we) MRAM[addr[AW-1:0]] <= wdata;
    end

    assign rdata = MRAM[addr[AW-1:0]];
endmodule

module top
    import riscv_pkg::*;
#(
    parameter int unsigned ROM_WORDS = 1024,
    parameter int unsigned RAM_WORDS = 1024
) (
    input  logic        CLK,
    input  logic        RESET_N,
    output logic [9:0]  RAM_ADDRESS,
    output logic [31:0] RAM_DATAIN,
    output logic [31:0] RAM_DATAOUT
);
    // RESET_N is active-high despite its legacy name
    logic        rst;
    logic [31:0] pc, pc_next, pc4, pc_target, instr, imm;
    logic [31:0] rs1_val, rs2_val, alu_a, alu_b, alu_res, ram_rdata, wb_data;
    logic [31:0] regs [0:31];
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        alu_zero, take;
    logic        reg_write, mem_write, a_sel_pc, b_sel_imm, is_branch, is_jal, is_jalr;
    alu_op_e     alu_op;
    imm_e        imm_type;
    wb_sel_e     wb_sel;

    assign rst    = RESET_N;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    rom #(.WORDS(ROM_WORDS)) ROM_INST (
        .CLK(CLK), .addr(pc[11:2]), .data(instr),
        .prog_we(1'b0), .prog_addr('0), .prog_data('0)
    );

    // Control decode; unknown opcodes fall through as NOPs
    always_comb begin
        reg_write = 1'b0; mem_write = 1'b0; a_sel_pc = 1'b0; b_sel_imm = 1'b0;
        is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
        alu_op = ALU_ADD; imm_type = IMM_I; wb_sel = WB_ALU;
        case (opcode)
            OPC_OP:     begin reg_write = 1'b1; alu_op = decode_alu(funct3, instr[30], 1'b1); end
            OPC_OP_IMM: begin reg_write = 1'b1; b_sel_imm = 1'b1; alu_op = decode_alu(funct3, instr[30], 1'b0); end
            OPC_LOAD:   begin reg_write = 1'b1; b_sel_imm = 1'b1; wb_sel = WB_MEM; end
            OPC_STORE:  begin mem_write = 1'b1; b_sel_imm = 1'b1; imm_type = IMM_S; end
            OPC_BRANCH: begin is_branch = 1'b1; alu_op = ALU_SUB; imm_type = IMM_B; end
            OPC_JAL:    begin reg_write = 1'b1; is_jal = 1'b1; imm_type = IMM_J; wb_sel = WB_PC4; end
            OPC_JALR:   begin reg_write = 1'b1; is_jalr = 1'b1; b_sel_imm = 1'b1; wb_sel = WB_PC4; end
            OPC_LUI:    begin reg_write = 1'b1; b_sel_imm = 1'b1; imm_type = IMM_U; alu_op = ALU_PASSB; end
            OPC_AUIPC:  begin reg_write = 1'b1; a_sel_pc = 1'b1; b_sel_imm = 1'b1; imm_type = IMM_U; end
            default:    ;
        endcase
    end

    assign imm     = gen_imm(instr, imm_type);
    assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign alu_a   = a_sel_pc  ? pc  : rs1_val;
    assign alu_b   = b_sel_imm ? imm : rs2_val;

    alu ALU_INST (.a(alu_a), .b(alu_b), .op(alu_op), .result(alu_res), .zero(alu_zero));

    // Branch condition: equality from the ALU subtract, ordering compared alongside
    always_comb begin
        case (funct3)
            3'b000:  take = alu_zero;
            3'b001:  take = !alu_zero;
            3'b100:  take = $signed(rs1_val) <  $signed(rs2_val);
            3'b101:  take = $signed(rs1_val) >= $signed(rs2_val);
            3'b110:  take = rs1_val <  rs2_val;
            3'b111:  take = rs1_val >= rs2_val;
            default: take = 1'b0;
        endcase
    end

    assign pc4       = pc + 32'd4;
    assign pc_target = pc + imm;

    // Next-PC selection
    always_comb begin
        pc_next = pc4;
        if (is_jal)                 pc_next = pc_target;
        else if (is_jalr)           pc_next = {alu_res[31:1], 1'b0};
        else if (is_branch && take) pc_next = pc_target;
    end

    // Program counter register
    always_ff @(posedge CLK) begin
        if (rst) pc <= '0;
        else     pc <= pc_next;
    end

    ram #(.WORDS(RAM_WORDS)) RAM_INST (
        .CLK(CLK), .we(mem_write && !rst), .addr(alu_res[11:2]),
        .wdata(rs2_val), .rdata(ram_rdata)
    );

    // Writeback source select
    always_comb begin
        case (wb_sel)
            WB_MEM:  wb_data = ram_rdata;
            WB_PC4:  wb_data = pc4;
            default: wb_data = alu_res;
        endcase
    end

    // Register file write; x0 writes dropped, contents survive reset
    always_ff @(posedge CLK) begin
        if (!rst && reg_write && rd != 5'd0) regs[rd] <= wb_data;
    end

    assign RAM_ADDRESS = rst ? '0 : alu_res[11:2];
    assign RAM_DATAIN  = rst ? '0 : rs2_val;
    assign RAM_DATAOUT = rst ? '0 : ram_rdata;

endmodule

// File: tb/tb_top.sv
// Directed-program bench for the single-cycle RV32I core.
module tb_top;
    logic        CLK;
    logic        RESET_N;
    logic [9:0]  RAM_ADDRESS;
    logic [31:0] RAM_DATAIN;
    logic [31:0] RAM_DATAOUT;
    int unsigned n_cmp;
    int unsigned n_err;

    top #(.ROM_WORDS(1024), .RAM_WORDS(1024)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .RAM_ADDRESS(RAM_ADDRESS),
        .RAM_DATAIN(RAM_DATAIN), .RAM_DATAOUT(RAM_DATAOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] opc);
        return {imm, rd, opc};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic clear_rom;
        for (int i = 0; i < 1024; i++) dut.ROM_INST.MROM[i] = 32'h0;
    endtask
    task automatic put(input int unsigned idx, input logic [31:0] w);
        dut.ROM_INST.MROM[idx] = w;
    endtask
    task automatic step(input int unsigned n);
        repeat (n) @(posedge CLK);
        #1;
    endtask
    task automatic do_reset(input string tag);
        RESET_N = 1'b1;
        step(2);
        chk({tag, "_rst_pc"}, dut.pc, 32'h0);
        chk({tag, "_rst_addr"}, {22'b0, RAM_ADDRESS}, 32'h0);
        chk({tag, "_rst_din"}, RAM_DATAIN, 32'h0);
        chk({tag, "_rst_dout"}, RAM_DATAOUT, 32'h0);
        RESET_N = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        RESET_N = 1'b1;

        // Reset and first instruction
        clear_rom();
        put(0, addi(5'd1, 5'd0, 12'd5));
        do_reset("t1");
        step(1);
        chk("t1_x1", dut.regs[1], 32'd5);
        chk("t1_pc", dut.pc, 32'h4);

        // ALU operations and x0
        clear_rom();
        put(0,  addi(5'd1, 5'd0, 12'hFFD));
        put(1,  addi(5'd2, 5'd0, 12'd7));
        put(2,  enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3));
        put(3,  enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4));
        put(4,  enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd5));
        put(5,  enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd6));
        put(6,  addi(5'd0, 5'd0, 12'd9));
        put(7,  enc_r(7'h00, 5'd2, 5'd0, 3'b000, 5'd7));
        put(8,  enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd8));
        put(9,  enc_i(12'h401, 5'd1, 3'b101, 5'd9,  7'b0010011));
        put(10, enc_i(12'h01C, 5'd1, 3'b101, 5'd10, 7'b0010011));
        put(11, enc_i(12'h004, 5'd2, 3'b001, 5'd11, 7'b0010011));
        put(12, enc_i(12'h0FF, 5'd1, 3'b111, 5'd12, 7'b0010011));
        put(13, enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd13));
        do_reset("t2");
        step(14);
        chk("add",  dut.regs[3],  32'd4);
        chk("sub",  dut.regs[4],  32'hFFFFFFF6);
        chk("slt",  dut.regs[5],  32'd1);
        chk("sltu", dut.regs[6],  32'd0);
        chk("x0",   dut.regs[0],  32'd0);
        chk("x0rd", dut.regs[7],  32'd7);
        chk("xor",  dut.regs[8],  32'hFFFFFFFA);
        chk("srai", dut.regs[9],  32'hFFFFFFFE);
        chk("srli", dut.regs[10], 32'h0000000F);
        chk("slli", dut.regs[11], 32'h00000070);
        chk("andi", dut.regs[12], 32'h000000FD);
        chk("or",   dut.regs[13], 32'hFFFFFFFF);
        chk("pc14", dut.pc,       32'h38);

        // Store, load, load-use
        clear_rom();
        put(0, addi(5'd1, 5'd0, 12'h055));
        put(1, enc_s(12'h008, 5'd1, 5'd0));
        put(2, enc_i(12'h008, 5'd0, 3'b010, 5'd2, 7'b0000011));
        put(3, enc_r(7'h00, 5'd2, 5'd2, 3'b000, 5'd3));
        do_reset("t3");
        step(1);
        chk("sw_addr", {22'b0, RAM_ADDRESS}, 32'd2);
        chk("sw_din",  RAM_DATAIN, 32'h55);
        chk("sw_pre",  dut.RAM_INST.MRAM[2], 32'h0);
        step(1);
        chk("sw_mem",  dut.RAM_INST.MRAM[2], 32'h55);
        chk("lw_addr", {22'b0, RAM_ADDRESS}, 32'd2);
        chk("lw_dout", RAM_DATAOUT, 32'h55);
        step(1);
        chk("lw_x2",   dut.regs[2], 32'h55);
        step(1);
        chk("lw_use",  dut.regs[3], 32'hAA);

        // BEQ taken, JAL, JALR
        clear_rom();
        put(4,  enc_b(13'h008, 5'd0, 5'd0, 3'b000));
        put(8,  enc_j(21'h00C, 5'd1));
        put(11, enc_i(12'h001, 5'd1, 3'b000, 5'd0, 7'b1100111));
        do_reset("t4");
        step(4);
        chk("nop_pc", dut.pc, 32'h10);
        step(1);
        chk("beq_pc", dut.pc, 32'h18);
        step(2);
        chk("pre_jal", dut.pc, 32'h20);
        step(1);
        chk("jal_pc", dut.pc, 32'h2C);
        chk("jal_x1", dut.regs[1], 32'h24);
        step(1);
        chk("jalr_pc", dut.pc, 32'h24);

        // BNE not taken
        clear_rom();
        put(4, enc_b(13'h008, 5'd0, 5'd0, 3'b001));
        do_reset("t5");
        step(5);
        chk("bne_pc", dut.pc, 32'h14);

        // Signed vs unsigned branches, backward branch
        clear_rom();
        put(0, addi(5'd1, 5'd0, 12'hFFF));
        put(1, enc_b(13'h008, 5'd0, 5'd1, 3'b100));
        put(3, enc_b(13'h008, 5'd0, 5'd1, 3'b110));
        put(4, enc_b(13'h008, 5'd1, 5'd0, 3'b101));
        put(6, enc_b(13'h008, 5'd1, 5'd0, 3'b111));
        put(7, enc_b(13'h1FE4, 5'd1, 5'd1, 3'b000));
        do_reset("t6");
        step(1); chk("b_pc0",  dut.pc, 32'h04);
        step(1); chk("blt",    dut.pc, 32'h0C);
        step(1); chk("bltu",   dut.pc, 32'h10);
        step(1); chk("bge",    dut.pc, 32'h18);
        step(1); chk("bgeu",   dut.pc, 32'h1C);
        step(1); chk("b_back", dut.pc, 32'h00);

        // LUI / AUIPC
        clear_rom();
        put(0, enc_u(20'h12345, 5'd1, 7'b0110111));
        put(2, enc_u(20'h00001, 5'd2, 7'b0010111));
        do_reset("t7");
        step(3);
        chk("lui",   dut.regs[1], 32'h12345000);
        chk("auipc", dut.regs[2], 32'h00001008);

        // Reset mid-program abandons register and memory writes
        clear_rom();
        put(0, addi(5'd10, 5'd0, 12'd7));
        put(1, addi(5'd10, 5'd10, 12'd1));
        put(2, enc_s(12'h010, 5'd10, 5'd0));
        do_reset("t8");
        step(1);
        chk("mr_x10a", dut.regs[10], 32'd7);
        RESET_N = 1'b1;
        step(1);
        chk("mr_pc1", dut.pc, 32'h0);
        chk("mr_x10b", dut.regs[10], 32'd7);
        RESET_N = 1'b0;
        step(2);
        chk("mr_x10c", dut.regs[10], 32'd8);
        chk("mr_pc2", dut.pc, 32'h8);
        RESET_N = 1'b1;
        #1;
        chk("mr_addr", {22'b0, RAM_ADDRESS}, 32'h0);
        chk("mr_din",  RAM_DATAIN, 32'h0);
        step(1);
        chk("mr_pc3", dut.pc, 32'h0);
        chk("mr_mem", dut.RAM_INST.MRAM[4], 32'h0);
        RESET_N = 1'b0;

        // Fibonacci F(0..9) to RAM words 0..9
        clear_rom();
        put(0,  addi(5'd1, 5'd0, 12'd0));
        put(1,  addi(5'd2, 5'd0, 12'd1));
        put(2,  addi(5'd3, 5'd0, 12'd0));
        put(3,  addi(5'd4, 5'd0, 12'd40));
        put(4,  enc_s(12'h000, 5'd1, 5'd3));
        put(5,  enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd5));
        put(6,  addi(5'd1, 5'd2, 12'd0));
        put(7,  addi(5'd2, 5'd5, 12'd0));
        put(8,  addi(5'd3, 5'd3, 12'd4));
        put(9,  enc_b(13'h1FEC, 5'd4, 5'd3, 3'b001));
        put(10, enc_j(21'h0, 5'd0));
        do_reset("t9");
        step(80);
        chk("fib0", dut.RAM_INST.MRAM[0], 32'd0);
        chk("fib1", dut.RAM_INST.MRAM[1], 32'd1);
        chk("fib5", dut.RAM_INST.MRAM[5], 32'd5);
        chk("fib9", dut.RAM_INST.MRAM[9], 32'd34);
        chk("fib_pc", dut.pc, 32'h28);
        chk("fib_x4", dut.regs[4], 32'd40);

        // Reset forcing with live RAM contents behind the address
        clear_rom();
        put(0, addi(5'd1, 5'd0, 12'h024));
        do_reset("t10");
        step(1);
        chk("t10_x1", dut.regs[1], 32'h24);
        chk("t10_pc", dut.pc, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
